dma_arbiter: RTL and testbench
==============================

# dma_arbiter

Round-robin arbiter sharing one DMA memory port between NCH DMA channel controllers: mp3, SD and ZX-side transfers. Each channel uses the same req/ack/end handshake. The block selects one pending channel, forwards its address, direction and write data to the memory sequencer, and returns the acknowledge and completion strobes to the owning channel. Up to OUTS accepted accesses may be outstanding at the memory side; completions are routed back by an in-order tag queue.

## Interface
- NCH, 4, number of requesting channels (2..8)
- AW, 22, DMA address width
- OUTS, 2, max outstanding accepted-but-not-completed accesses (1..4)
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- chan_en  in  NCH  per-channel enable; disabled channels are never granted
- prio_fixed  in  1  1 = fixed priority (channel 0 highest), 0 = round-robin
- req  in  NCH  per-channel request, held by requester until its ack
- addr  in  NCH*AW  channel k address at [k*AW +: AW]
- rnw  in  NCH  1 = read, 0 = write
- wd  in  NCH*8  channel k write data at [k*8 +: 8]
- ack  out  NCH  one-cycle: request accepted; requester may change addr/drop req at next edge
- dma_end  out  NCH  one-cycle: access done, read data valid on dma_rd
- dma_rd  out  8  read data, broadcast to all channels (= mem_rd)
- mem_req  out  1  memory request, held until mem_ack
- mem_addr  out  AW  latched address of granted channel
- mem_rnw  out  1  latched direction
- mem_wd  out  8  latched write data
- mem_ack  in  1  memory accepted current request
- mem_rvalid  in  1  one-cycle completion of oldest outstanding access
- mem_rd  in  8  read data, valid with mem_rvalid
- busy  out  1  mem_req high or tag queue non-empty
- err  out  1  sticky: mem_rvalid arrived with empty tag queue

## Operation
- FSM has two states: ARB and WAIT.
- ARB:
  - Candidate set = req & chan_en.
  - If the set is non-empty and the tag queue is not full, pick the winner.
  - Latch the winner's addr/rnw/wd into mem_* and its index into gnt.
  - Assert mem_req and go to WAIT.
  - Otherwise stay in ARB with mem_req low.
- Winner selection:
  - prio_fixed=1: lowest-index candidate.
  - prio_fixed=0: first candidate scanning from rr_ptr upward, modulo NCH.
- WAIT:
  - mem_req held high and mem_* held stable.
  - Changes to chan_en or req are ignored; a started access is never withdrawn.
  - On mem_ack:
    - ack[gnt] = 1 combinationally in that cycle.
    - Push gnt into the tag queue.
    - rr_ptr <= gnt+1 (mod NCH).
    - mem_req <= 0, go to ARB.
- Completion:
  - On mem_rvalid with the queue non-empty: dma_end[head] = 1 in the same cycle, then pop.
  - dma_rd = mem_rd always.
- Simultaneous mem_ack push and mem_rvalid pop in one cycle:
  - Both take effect; occupancy is unchanged.
  - A full queue may push in the same cycle it pops.
  - The full check in ARB uses registered occupancy, so no bypass is needed.
- Empty-queue mem_rvalid: dma_end stays all-zero and err is set. err clears only on reset.
- Reset (async) leaves:
  - state ARB, mem_req 0, mem_addr/mem_wd 0, mem_rnw 1.
  - rr_ptr 0, queue empty, err 0, busy 0.
  - ack/dma_end are 0 because their sources are 0.
- Reset mid-access: all tags are discarded. Completions arriving after reset set err.

## Timing
- Requirements on requesters and memory:
  - req must be high at edge t for arbitration in cycle t.
  - Requesters keep req high until ack.
  - mem_* is valid only while mem_req is high.
- Arbitration latency:
  - mem_req rises at edge t+1 after req is sampled high in ARB at edge t.
  - ack follows in the same cycle as mem_ack, earliest cycle t+1.
- Throughput: each accept is followed by one ARB cycle, so peak rate is one accepted access per 2 clocks.
- A requester that re-asserts req right after its ack competes at the next ARB cycle with lowest round-robin priority.
- dma_end is in-order and has zero added latency relative to mem_rvalid.

## Structure
- Shared package dma_pkg:
  - DMA_AW=22.
  - State encoding ARB/WAIT.
  - Channel index constants: CH_MP3, CH_SD, CH_ZX, CH_SPARE.
- Sub-module dma_tag_fifo:
  - OUTS-deep, $clog2(NCH)-bit-wide in-order queue.
  - Ports: push, pop, din, dout, empty, full, count.
  - Simultaneous push/pop is legal when full.
- Round-robin select is a combinational function in the top; no sub-module.

## Test plan
- Single channel: req[1]=1 read addr 0x12345; mem_ack on the 2nd WAIT cycle; mem_rvalid 3 cycles later with mem_rd=0xA5 -> mem_addr=0x12345 and mem_rnw=1; ack[1] one pulse; dma_end[1] one pulse with dma_rd=0xA5.
- Round-robin: req=4'b1111 held continuously, mem_ack immediate -> grant order 0,1,2,3,0,…; with prio_fixed=1 -> always channel 0.
- Outstanding limit: OUTS=2, mem_rvalid withheld -> exactly 2 acks, then mem_req stays low. One mem_rvalid in the same cycle as a new mem_ack -> both counted; dma_end goes to the oldest tag.
- Enable masking: chan_en=4'b1011 with req=4'b0100 -> no mem_req. chan_en dropped while in WAIT -> access still completes and is acked.
- err: mem_rvalid with empty queue -> err=1 sticky, dma_end=0. Assert rst_n low mid-access -> all outputs reset within the same cycle (async).

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA memory-port arbiter.
package dma_pkg;

    localparam int unsigned DMA_AW = 22;

    typedef enum logic {
        ARB  = 1'b0,
        WAIT = 1'b1
    } dma_state_e;

    localparam int unsigned CH_MP3   = 0;
    localparam int unsigned CH_SD    = 1;
    localparam int unsigned CH_ZX    = 2;
    localparam int unsigned CH_SPARE = 3;

endpackage

// File: rtl/dma_tag_fifo.sv
// In-order tag queue tracking which channel owns each outstanding memory access.
module dma_tag_fifo
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 dout,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A full queue may still accept a push when a pop frees a slot in the same cycle.
    assign do_pop  = pop & (count_q != '0);
    assign do_push = push & ((count_q != CW'(DEPTH)) | do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;

endmodule

// File: rtl/dma_arbiter.sv
// Round-robin / fixed-priority arbiter sharing one DMA memory port between NCH channels,
// with in-order completion routing through a tag queue.
module dma_arbiter
    import dma_pkg::*;
#(
    parameter int unsigned NCH  = 4,
    parameter int unsigned AW   = DMA_AW,
    parameter int unsigned OUTS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    chan_en,
    input  logic              prio_fixed,
    input  logic [NCH-1:0]    req,
    input  logic [NCH*AW-1:0] addr,
    input  logic [NCH-1:0]    rnw,
    input  logic [NCH*8-1:0]  wd,
    output logic [NCH-1:0]    ack,
    output logic [NCH-1:0]    dma_end,
    output logic [7:0]        dma_rd,
    output logic              mem_req,
    output logic [AW-1:0]     mem_addr,
    output logic              mem_rnw,
    output logic [7:0]        mem_wd,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [7:0]        mem_rd,
    output logic              busy,
    output logic              err
);

    localparam int unsigned IW = $clog2(NCH);
    localparam int unsigned CW = $clog2(OUTS + 1);

    dma_state_e      state_q, state_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic            mem_rnw_q, mem_rnw_d;
    logic [7:0]      mem_wd_q, mem_wd_d;
    logic            err_q, err_d;

    logic [NCH-1:0]  cand;
    logic [IW:0]     sel;
    logic            tag_push, tag_pop;
    logic [IW-1:0]   tag_head;
    logic            tag_empty, tag_full;
    logic [CW-1:0]   tag_count;

    // Returns {found, index}; fixed mode scans from 0, round-robin from ptr upward.
    function automatic logic [IW:0] pick(input logic [NCH-1:0] c,
                                         input logic           fixed,
                                         input logic [IW-1:0]  ptr);
        logic          found;
        logic [IW-1:0] idx;
        int unsigned   start;
        int unsigned   k;
        found = 1'b0;
        idx   = '0;
        start = fixed ? 0 : int'(ptr);
        for (int unsigned i = 0; i < NCH; i++) begin
            k = (start + i) % NCH;
            if (!found && c[IW'(k)]) begin
                found = 1'b1;
                idx   = IW'(k);
            end
        end
        return {found, idx};
    endfunction

    assign cand = req & chan_en;
    assign sel  = pick(cand, prio_fixed, rr_ptr_q);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_ptr_d   = rr_ptr_q;
        mem_addr_d = mem_addr_q;
        mem_rnw_d  = mem_rnw_q;
        mem_wd_d   = mem_wd_q;
        ack        = '0;
        tag_push   = 1'b0;
        case (state_q)
            ARB: begin
                if (sel[IW] && !tag_full) begin
                    gnt_d   = sel[IW-1:0];
                    state_d = WAIT;
                    for (int unsigned i = 0; i < NCH; i++) begin
                        if (sel[IW-1:0] == IW'(i)) begin
                            mem_addr_d = addr[i*AW +: AW];
                            mem_rnw_d  = rnw[i];
                            mem_wd_d   = wd[i*8 +: 8];
                        end
                    end
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    ack[gnt_q] = 1'b1;
                    tag_push   = 1'b1;
                    rr_ptr_d   = (gnt_q == IW'(NCH - 1)) ? '0 : gnt_q + 1'b1;
                    state_d    = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    assign tag_pop = mem_rvalid & ~tag_empty;
    assign err_d   = err_q | (mem_rvalid & tag_empty);

    always_comb begin
        dma_end = '0;
        if (tag_pop) begin
            dma_end[tag_head] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB;
            gnt_q      <= '0;
            rr_ptr_q   <= '0;
            mem_addr_q <= '0;
            mem_rnw_q  <= 1'b1;
            mem_wd_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_ptr_q   <= rr_ptr_d;
            mem_addr_q <= mem_addr_d;
            mem_rnw_q  <= mem_rnw_d;
            mem_wd_q   <= mem_wd_d;
            err_q      <= err_d;
        end
    end

    dma_tag_fifo #(
        .DEPTH (OUTS),
        .W     (IW)
    ) u_tags (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tag_push),
        .pop   (tag_pop),
        .din   (gnt_q),
        .dout  (tag_head),
        .empty (tag_empty),
        .full  (tag_full),
        .count (tag_count)
    );

    assign mem_req  = (state_q == WAIT);
    assign mem_addr = mem_addr_q;
    assign mem_rnw  = mem_rnw_q;
    assign mem_wd   = mem_wd_q;
    assign dma_rd   = mem_rd;
    assign busy     = mem_req | (tag_count != '0);
    assign err      = err_q;

endmodule

// File: tb/tb_dma_arbiter.sv
// Directed bench for dma_arbiter: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_dma_arbiter;

    localparam int NCH  = 4;
    localparam int AW   = 22;
    localparam int OUTS = 2;
    localparam int NV   = 18;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    chan_en;
    logic              prio_fixed;
    logic [NCH-1:0]    req;
    logic [NCH*AW-1:0] addr;
    logic [NCH-1:0]    rnw;
    logic [NCH*8-1:0]  wd;
    logic [NCH-1:0]    ack;
    logic [NCH-1:0]    dma_end;
    logic [7:0]        dma_rd;
    logic              mem_req;
    logic [AW-1:0]     mem_addr;
    logic              mem_rnw;
    logic [7:0]        mem_wd;
    logic              mem_ack;
    logic              mem_rvalid;
    logic [7:0]        mem_rd;
    logic              busy;
    logic              err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  en;
        logic [3:0]  rq;
        logic [3:0]  rw;
        logic        mack;
        logic        mrv;
        logic [7:0]  mrd;
        logic        e_req;
        logic [3:0]  e_ack;
        logic [3:0]  e_end;
        logic        e_busy;
        logic        e_err;
        logic        chk_mem;
        logic [21:0] e_addr;
        logic        e_rnw;
        logic [7:0]  e_wd;
    } vec_t;

    vec_t tv [NV];

    dma_arbiter #(
        .NCH  (NCH),
        .AW   (AW),
        .OUTS (OUTS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .chan_en    (chan_en),
        .prio_fixed (prio_fixed),
        .req        (req),
        .addr       (addr),
        .rnw        (rnw),
        .wd         (wd),
        .ack        (ack),
        .dma_end    (dma_end),
        .dma_rd     (dma_rd),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rnw    (mem_rnw),
        .mem_wd     (mem_wd),
        .mem_ack    (mem_ack),
        .mem_rvalid (mem_rvalid),
        .mem_rd     (mem_rd),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] ch_addr(input int k);
        case (k)
            0:       return 22'h00100;
            1:       return 22'h12345;
            2:       return 22'h3ABCD;
            default: return 22'h0FFFF;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, then let outputs settle.
    task automatic cyc(input logic [3:0] rq, input logic mack, input logic mrv, input logic [7:0] mrd);
        @(posedge clk);
        #1;
        req        = rq;
        mem_ack    = mack;
        mem_rvalid = mrv;
        mem_rd     = mrd;
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        req        = '0;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        chan_en    = 4'hF;
        prio_fixed = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_rr(input logic fixed);
        logic [1:0] exp_ch;
        logic [1:0] prev;
        prev       = '0;
        prio_fixed = fixed;
        for (int n = 0; n < 8; n++) begin
            cyc(4'hF, 1'b0, (n > 0), 8'(n));
            chk($sformatf("rr%0d.arb%0d.mem_req", fixed, n), 32'(mem_req), 32'd0);
            chk($sformatf("rr%0d.arb%0d.dma_end", fixed, n), 32'(dma_end),
                (n > 0) ? (32'd1 << prev) : 32'd0);
            exp_ch = fixed ? 2'd0 : 2'(n);
            cyc(4'hF, 1'b1, 1'b0, 8'h00);
            chk($sformatf("rr%0d.wait%0d.mem_req", fixed, n), 32'(mem_req), 32'd1);
            chk($sformatf("rr%0d.wait%0d.ack", fixed, n), 32'(ack), 32'd1 << exp_ch);
            chk($sformatf("rr%0d.wait%0d.mem_addr", fixed, n), 32'(mem_addr), 32'(ch_addr(int'(exp_ch))));
            prev = exp_ch;
        end
        cyc(4'h0, 1'b0, 1'b1, 8'hEE);
        chk($sformatf("rr%0d.drain.dma_end", fixed), 32'(dma_end), 32'd1 << prev);
        cyc(4'h0, 1'b0, 1'b0, 8'h00);
        chk($sformatf("rr%0d.drain.busy", fixed), 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        addr       = {22'h0FFFF, 22'h3ABCD, 22'h12345, 22'h00100};
        wd         = {8'h53, 8'h52, 8'h51, 8'h50};
        rnw        = 4'hF;
        rst_n      = 1'b0;
        chan_en    = 4'hF;
        prio_fixed = 1'b0;
        req        = '0;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rd     = '0;

        //        en    rq    rw    mack  mrv   mrd     req   ack   end   busy  err   chkm  addr        rnw   wd
        tv[0]  = '{4'hF, 4'h2, 4'hF, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 22'h0,      1'b0, 8'h00};
        tv[1]  = '{4'hF, 4'h2, 4'hF, 1'b0, 1'b0, 8'h00, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 22'h12345,  1'b1, 8'h51};
        tv[2]  = '{4'hF, 4'h2, 4'hF, 1'b1, 1'b0, 8'h00, 1'b1, 4'h2, 4'h0, 1'b1, 1'b0, 1'b1, 22'h12345,  1'b1, 8'h51};
        tv[3]  = '{4'hF, 4'h0, 4'hF, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 22'h0,      1'b0, 8'h00};
        tv[4]  = '{4'hF, 4'h0, 4'hF, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 22'h0,      1'b0, 8'h00};
        tv[5]  = '{4'hF, 4'h0, 4'hF, 1'b0, 1'b1, 8'hA5, 1'b0, 4'h0, 4'h2, 1'b1, 1'b0, 1'b0, 22'h0,      1'b0, 8'h00};
        tv[6]  = '{4'hF, 4'h0, 4'hF, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 22'h0,      1'b0, 8'h00};
        tv[7]  = '{4'hB, 4'h4, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 22'h0,      1'b0, 8'h00};
        tv[8]  = '{4'hB, 4'h4, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 22'h0,      1'b0, 8'h00};
        tv[9]  = '{4'hF, 4'h4, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 22'h0,      1'b0, 8'h00};
        tv[10] = '{4'h0, 4'h4, 4'h0, 1'b0, 1'b0, 8'h00, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 22'h3ABCD,  1'b0, 8'h52};
        tv[11] = '{4'h0, 4'h4, 4'hF, 1'b1, 1'b0, 8'h00, 1'b1, 4'h4, 4'h0, 1'b1, 1'b0, 1'b1, 22'h3ABCD,  1'b0, 8'h52};
        tv[12] = '{4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 22'h0,      1'b0, 8'h00};
        tv[13] = '{4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 8'h77, 1'b0, 4'h0, 4'h4, 1'b1, 1'b0, 1'b0, 22'h0,      1'b0, 8'h00};
        tv[14] = '{4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 22'h0,      1'b0, 8'h00};
        tv[15] = '{4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 8'h99, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 22'h0,      1'b0, 8'h00};
        tv[16] = '{4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 22'h0,      1'b0, 8'h00};
        tv[17] = '{4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 22'h0,      1'b0, 8'h00};

        @(posedge clk);
        @(posedge clk);
        #2;
        chk("rst.mem_req",  32'(mem_req),  32'd0);
        chk("rst.mem_addr", 32'(mem_addr), 32'd0);
        chk("rst.mem_rnw",  32'(mem_rnw),  32'd1);
        chk("rst.mem_wd",   32'(mem_wd),   32'd0);
        chk("rst.busy",     32'(busy),     32'd0);
        chk("rst.err",      32'(err),      32'd0);
        chk("rst.ack",      32'(ack),      32'd0);
        chk("rst.dma_end",  32'(dma_end),  32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            chan_en    = tv[i].en;
            req        = tv[i].rq;
            rnw        = tv[i].rw;
            mem_ack    = tv[i].mack;
            mem_rvalid = tv[i].mrv;
            mem_rd     = tv[i].mrd;
            #1;
            chk($sformatf("v%0d.mem_req", i), 32'(mem_req), 32'(tv[i].e_req));
            chk($sformatf("v%0d.ack", i),     32'(ack),     32'(tv[i].e_ack));
            chk($sformatf("v%0d.dma_end", i), 32'(dma_end), 32'(tv[i].e_end));
            chk($sformatf("v%0d.busy", i),    32'(busy),    32'(tv[i].e_busy));
            chk($sformatf("v%0d.err", i),     32'(err),     32'(tv[i].e_err));
            chk($sformatf("v%0d.dma_rd", i),  32'(dma_rd),  32'(tv[i].mrd));
            if (tv[i].chk_mem) begin
                chk($sformatf("v%0d.mem_addr", i), 32'(mem_addr), 32'(tv[i].e_addr));
                chk($sformatf("v%0d.mem_rnw", i),  32'(mem_rnw),  32'(tv[i].e_rnw));
                chk($sformatf("v%0d.mem_wd", i),   32'(mem_wd),   32'(tv[i].e_wd));
            end
        end

        do_reset();
        run_rr(1'b0);
        run_rr(1'b1);
        prio_fixed = 1'b0;

        // Outstanding limit: two accepts without completions, then a stall.
        do_reset();
        cyc(4'h3, 1'b0, 1'b0, 8'h00);
        chk("os.c1.mem_req", 32'(mem_req), 32'd0);
        cyc(4'h3, 1'b1, 1'b0, 8'h00);
        chk("os.c2.ack", 32'(ack), 32'h1);
        cyc(4'h3, 1'b0, 1'b0, 8'h00);
        chk("os.c3.mem_req", 32'(mem_req), 32'd0);
        cyc(4'h3, 1'b1, 1'b0, 8'h00);
        chk("os.c4.ack", 32'(ack), 32'h2);
        for (int s = 0; s < 3; s++) begin
            cyc(4'h3, 1'b0, 1'b0, 8'h00);
            chk($sformatf("os.stall%0d.mem_req", s), 32'(mem_req), 32'd0);
            chk($sformatf("os.stall%0d.busy", s),    32'(busy),    32'd1);
        end
        cyc(4'h3, 1'b0, 1'b1, 8'h3C);
        chk("os.c8.dma_end", 32'(dma_end), 32'h1);
        chk("os.c8.dma_rd",  32'(dma_rd),  32'h3C);
        chk("os.c8.mem_req", 32'(mem_req), 32'd0);
        cyc(4'h3, 1'b0, 1'b0, 8'h00);
        chk("os.c9.mem_req", 32'(mem_req), 32'd0);
        cyc(4'h3, 1'b1, 1'b1, 8'h4D);
        chk("os.c10.mem_req",  32'(mem_req),  32'd1);
        chk("os.c10.ack",      32'(ack),      32'h1);
        chk("os.c10.dma_end",  32'(dma_end),  32'h2);
        chk("os.c10.mem_addr", 32'(mem_addr), 32'(ch_addr(0)));
        cyc(4'h3, 1'b0, 1'b0, 8'h00);
        chk("os.c11.mem_req", 32'(mem_req), 32'd0);
        cyc(4'h3, 1'b1, 1'b0, 8'h00);
        chk("os.c12.ack", 32'(ack), 32'h2);
        cyc(4'h0, 1'b0, 1'b0, 8'h00);
        chk("os.c13.busy", 32'(busy), 32'd1);
        cyc(4'h0, 1'b0, 1'b0, 8'h00);
        chk("os.c14.mem_req", 32'(mem_req), 32'd0);
        cyc(4'h0, 1'b0, 1'b1, 8'h11);
        chk("os.c15.dma_end", 32'(dma_end), 32'h1);
        cyc(4'h0, 1'b0, 1'b1, 8'h22);
        chk("os.c16.dma_end", 32'(dma_end), 32'h2);
        cyc(4'h0, 1'b0, 1'b0, 8'h00);
        chk("os.c17.busy", 32'(busy), 32'd0);
        chk("os.c17.err",  32'(err),  32'd0);

        // Asynchronous reset in the middle of an access with a tag outstanding.
        do_reset();
        cyc(4'h1, 1'b0, 1'b0, 8'h00);
        chk("ar.arb.mem_req", 32'(mem_req), 32'd0);
        cyc(4'h1, 1'b1, 1'b0, 8'h00);
        chk("ar.w1.ack", 32'(ack), 32'h1);
        cyc(4'h1, 1'b0, 1'b0, 8'h00);
        chk("ar.arb2.busy", 32'(busy), 32'd1);
        cyc(4'h1, 1'b1, 1'b1, 8'h5A);
        chk("ar.w2.ack",     32'(ack),     32'h1);
        chk("ar.w2.dma_end", 32'(dma_end), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.rst.mem_req",  32'(mem_req),  32'd0);
        chk("ar.rst.ack",      32'(ack),      32'd0);
        chk("ar.rst.dma_end",  32'(dma_end),  32'd0);
        chk("ar.rst.busy",     32'(busy),     32'd0);
        chk("ar.rst.mem_addr", 32'(mem_addr), 32'd0);
        chk("ar.rst.mem_rnw",  32'(mem_rnw),  32'd1);
        chk("ar.rst.err",      32'(err),      32'd0);
        req        = '0;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(4'h0, 1'b0, 1'b1, 8'h66);
        chk("ar.late.dma_end", 32'(dma_end), 32'd0);
        cyc(4'h0, 1'b0, 1'b0, 8'h00);
        chk("ar.late.err", 32'(err), 32'd1);
        cyc(4'h0, 1'b0, 1'b0, 8'h00);
        chk("ar.sticky.err", 32'(err), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
